// File: rtl/lcd_seq_pkg.sv
// Shared types and constants for the LCD command sequencer.
// The optional cursor tracker is enabled with LCD_SEQ_AUTOWRAP_EN (see lcd_seq_ctrl).
package lcd_seq_pkg;

    typedef enum logic [2:0] {
        StPwrupWait,
        StInitIssue,
        StInitWait,
        StIdle,
        StIssue,
        StWait
    } seq_state_e;

    localparam int unsigned INIT_LEN = 6;

    localparam logic [7:0] INIT_B0 = 8'h33;
    localparam logic [7:0] INIT_B1 = 8'h32;
    localparam logic [7:0] INIT_B2 = 8'h28;
    localparam logic [7:0] INIT_B3 = 8'h0C;
    localparam logic [7:0] INIT_B4 = 8'h01;
    localparam logic [7:0] INIT_B5 = 8'h06;

    localparam logic [7:0] CMD_CLEAR    = 8'h01;
    localparam logic [7:0] CMD_HOME     = 8'h02;
    localparam logic [7:0] CMD_DDRAM_L0 = 8'h80;
    localparam logic [7:0] CMD_DDRAM_L1 = 8'hC0;

    localparam int unsigned NUM_COLS = 16;

    // Clear (0x01) and home (0x02/0x03) need the long execution time.
    function automatic logic is_long_cmd(logic rs, logic [7:0] data);
        return !rs && (data[7:2] == 6'd0) && (data != 8'd0);
    endfunction

endpackage

// File: rtl/lcd_seq_ctrl_if.sv
// Valid/ready byte handshake between a command source and the LCD sequencer.
interface lcd_seq_ctrl_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_rs;
    logic [7:0] cmd_data;

    modport master (
        output cmd_valid,
        output cmd_rs,
        output cmd_data,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_rs,
        input  cmd_data,
        output cmd_ready
    );
endinterface

// File: rtl/lcd_init_rom.sv
// HD44780 4-bit init byte table, indexed combinationally.
module lcd_init_rom
    import lcd_seq_pkg::*;
(
    input  logic [2:0] idx,
    output logic [7:0] data
);

    always_comb begin
        data = 8'h00;
        case (idx)
            3'd0:    data = INIT_B0;
            3'd1:    data = INIT_B1;
            3'd2:    data = INIT_B2;
            3'd3:    data = INIT_B3;
            3'd4:    data = INIT_B4;
            3'd5:    data = INIT_B5;
            default: data = 8'h00;
        endcase
    end

endmodule

// File: rtl/lcd_seq_ctrl.sv
// Power-up wait, fixed init sequence, then one lcd_start per accepted byte with a fixed wait.
// Define LCD_SEQ_AUTOWRAP_EN to build the 16x2 cursor tracker with automatic line wrap.
module lcd_seq_ctrl
    import lcd_seq_pkg::*;
#(
    parameter int unsigned CNT_W     = 20,
    parameter int unsigned PWRUP_CYC = 750000,
    parameter int unsigned WR_CYC    = 64,
    parameter int unsigned EXEC_CYC  = 2000,
    parameter int unsigned LONG_CYC  = 82000
) (
    input  logic          clk,
    input  logic          rst,
    lcd_seq_ctrl_if.slave cmd,
    output logic          init_done,
    output logic          busy,
    output logic          lcd_start,
    output logic          lcd_rs,
    output logic          lcd_rw,
    output logic [7:0]    lcd_data
);

    localparam longint unsigned CntMax = (longint'(1) << CNT_W) - 1;

    if (CNT_W < 2 || CNT_W > 32 || PWRUP_CYC == 0 || WR_CYC == 0 || EXEC_CYC == 0 ||
        longint'(PWRUP_CYC) > CntMax ||
        longint'(WR_CYC) + longint'(EXEC_CYC) > CntMax ||
        longint'(WR_CYC) + longint'(LONG_CYC) > CntMax) begin : g_cfg_check
        $error("lcd_seq_ctrl: delay parameters do not fit the CNT_W-bit counter");
    end

    // Loads are wait-1: the issue cycle itself counts as the first wait cycle.
    localparam logic [CNT_W-1:0] PwrupLoad = CNT_W'(PWRUP_CYC - 1);
    localparam logic [CNT_W-1:0] ShortLoad = CNT_W'(WR_CYC + EXEC_CYC - 1);
    localparam logic [CNT_W-1:0] LongLoad  = CNT_W'(WR_CYC + LONG_CYC - 1);

    function automatic logic [CNT_W-1:0] wait_load(logic rs, logic [7:0] data);
        return is_long_cmd(rs, data) ? LongLoad : ShortLoad;
    endfunction

    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_dec;
    logic [2:0]       idx_q, idx_d, rom_idx;
    logic [7:0]       rom_byte;
    logic             cnt_zero;
    logic             ready_q, ready_d;
    logic             init_done_q, init_done_d;
    logic             busy_q, busy_d;
    logic             start_q, start_d;
    logic             rs_q, rs_d;
    logic [7:0]       data_q, data_d;
    logic             accept;

`ifdef LCD_SEQ_AUTOWRAP_EN
    logic [3:0] col_q, col_d;
    logic       line_q, line_d;
    logic       wrap_pend_q, wrap_pend_d;
`endif

    // ROM is addressed with the index of the byte about to be issued.
    assign rom_idx = (state_q == StPwrupWait) ? 3'd0 : idx_q + 3'd1;

    lcd_init_rom u_init_rom (
        .idx  (rom_idx),
        .data (rom_byte)
    );

    assign cnt_zero = (cnt_q == '0);
    assign cnt_dec  = cnt_q - CNT_W'(1);
    assign accept   = cmd.cmd_valid && ready_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        init_done_d = init_done_q;
        rs_d        = rs_q;
        data_d      = data_q;
        start_d     = 1'b0;
`ifdef LCD_SEQ_AUTOWRAP_EN
        col_d       = col_q;
        line_d      = line_q;
        wrap_pend_d = wrap_pend_q;
`endif
        case (state_q)
            StPwrupWait: begin
                if (cnt_zero) begin
                    state_d = StInitIssue;
                    idx_d   = 3'd0;
                    start_d = 1'b1;
                    rs_d    = 1'b0;
                    data_d  = rom_byte;
                    cnt_d   = wait_load(1'b0, rom_byte);
                end else begin
                    cnt_d = cnt_dec;
                end
            end
            StInitIssue: begin
                cnt_d   = cnt_dec;
                state_d = StInitWait;
            end
            StInitWait: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_dec;
                end else if (idx_q == 3'(INIT_LEN - 1)) begin
                    state_d     = StIdle;
                    init_done_d = 1'b1;
`ifdef LCD_SEQ_AUTOWRAP_EN
                    col_d       = 4'd0;
                    line_d      = 1'b0;
                    wrap_pend_d = 1'b0;
`endif
                end else begin
                    state_d = StInitIssue;
                    idx_d   = idx_q + 3'd1;
                    start_d = 1'b1;
                    rs_d    = 1'b0;
                    data_d  = rom_byte;
                    cnt_d   = wait_load(1'b0, rom_byte);
                end
            end
            StIdle: begin
                if (accept) begin
                    state_d = StIssue;
                    start_d = 1'b1;
                    rs_d    = cmd.cmd_rs;
                    data_d  = cmd.cmd_data;
                    cnt_d   = wait_load(cmd.cmd_rs, cmd.cmd_data);
`ifdef LCD_SEQ_AUTOWRAP_EN
                    if (cmd.cmd_rs) begin
                        if (col_q == 4'(NUM_COLS - 1)) begin
                            col_d       = 4'd0;
                            line_d      = ~line_q;
                            wrap_pend_d = 1'b1;
                        end else begin
                            col_d = col_q + 4'd1;
                        end
                    end else if (is_long_cmd(1'b0, cmd.cmd_data)) begin
                        col_d  = 4'd0;
                        line_d = 1'b0;
                    end else if (cmd.cmd_data[7]) begin
                        line_d = cmd.cmd_data[6];
                        col_d  = cmd.cmd_data[3:0];
                    end
`endif
                end
            end
            StIssue: begin
                cnt_d   = cnt_dec;
                state_d = StWait;
            end
            StWait: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_dec;
                end else begin
                    state_d = StIdle;
`ifdef LCD_SEQ_AUTOWRAP_EN
                    // line_q already holds the new line, so it selects the target DDRAM row.
                    if (wrap_pend_q) begin
                        state_d     = StIssue;
                        wrap_pend_d = 1'b0;
                        start_d     = 1'b1;
                        rs_d        = 1'b0;
                        data_d      = line_q ? CMD_DDRAM_L1 : CMD_DDRAM_L0;
                        cnt_d       = ShortLoad;
                    end
`endif
                end
            end
            default: begin
                state_d = StPwrupWait;
                cnt_d   = PwrupLoad;
            end
        endcase
        ready_d = (state_d == StIdle);
        busy_d  = (state_d != StIdle);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StPwrupWait;
            cnt_q       <= PwrupLoad;
            idx_q       <= 3'd0;
            ready_q     <= 1'b0;
            init_done_q <= 1'b0;
            busy_q      <= 1'b1;
            start_q     <= 1'b0;
            rs_q        <= 1'b0;
            data_q      <= 8'h00;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            ready_q     <= ready_d;
            init_done_q <= init_done_d;
            busy_q      <= busy_d;
            start_q     <= start_d;
            rs_q        <= rs_d;
            data_q      <= data_d;
        end
    end

`ifdef LCD_SEQ_AUTOWRAP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q       <= 4'd0;
            line_q      <= 1'b0;
            wrap_pend_q <= 1'b0;
        end else begin
            col_q       <= col_d;
            line_q      <= line_d;
            wrap_pend_q <= wrap_pend_d;
        end
    end
`endif

    assign cmd.cmd_ready = ready_q;
    assign init_done     = init_done_q;
    assign busy          = busy_q;
    assign lcd_start     = start_q;
    assign lcd_rs        = rs_q;
    assign lcd_rw        = 1'b0;
    assign lcd_data      = data_q;

endmodule

// File: tb/tb_lcd_seq_ctrl.sv
// Bench for lcd_seq_ctrl: timeline model of expected lcd_start events vs. a recorded log.
// Build with LCD_SEQ_AUTOWRAP_EN to also exercise the line-wrap inserts.
module tb_lcd_seq_ctrl;

    localparam int PWRUP = 100;
    localparam int WR    = 40;
    localparam int EXEC  = 10;
    localparam int LONG  = 50;

    typedef struct {
        int         t;
        logic       rs;
        logic [7:0] d;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       init_done, busy, lcd_start, lcd_rs, lcd_rw;
    logic [7:0] lcd_data;
    int         cyc;
    int         n_pass = 0;
    int         n_total = 0;
    int         ready_at;
    int         init_exp;
    int         m_col;
    logic       m_line;
    logic       bad_rdy = 1'b0;
    ev_t        obs_q[$];
    ev_t        exp_q[$];
    logic [7:0] init_rom [6] = '{8'h33, 8'h32, 8'h28, 8'h0C, 8'h01, 8'h06};

    lcd_seq_ctrl_if cmd_if ();

    lcd_seq_ctrl #(
        .CNT_W     (20),
        .PWRUP_CYC (PWRUP),
        .WR_CYC    (WR),
        .EXEC_CYC  (EXEC),
        .LONG_CYC  (LONG)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd       (cmd_if),
        .init_done (init_done),
        .busy      (busy),
        .lcd_start (lcd_start),
        .lcd_rs    (lcd_rs),
        .lcd_rw    (lcd_rw),
        .lcd_data  (lcd_data)
    );

    always #5 clk = ~clk;

    // Cycle index = number of rising edges since reset release.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (rst === 1'b0 && lcd_start === 1'b1) begin
            ev_t e;
            e.t  = cyc;
            e.rs = lcd_rs;
            e.d  = lcd_data;
            obs_q.push_back(e);
        end
        if (rst === 1'b0 && init_done !== 1'b1 && cmd_if.cmd_ready !== 1'b0) bad_rdy <= 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    function automatic int exec_time(input logic rs, input logic [7:0] d);
        return WR + ((!rs && d != 8'd0 && d < 8'd4) ? LONG : EXEC);
    endfunction

    task automatic push_exp(input int t, input logic rs, input logic [7:0] d);
        ev_t e;
        e.t  = t;
        e.rs = rs;
        e.d  = d;
        exp_q.push_back(e);
    endtask

    task automatic model_init();
        int t = PWRUP;
        for (int i = 0; i < 6; i++) begin
            push_exp(t, 1'b0, init_rom[i]);
            t += exec_time(1'b0, init_rom[i]);
        end
        init_exp = t;
        ready_at = t;
        m_col    = 0;
        m_line   = 1'b0;
    endtask

    task automatic model_accept(input int t, input logic rs, input logic [7:0] d);
        push_exp(t + 1, rs, d);
        ready_at = t + 1 + exec_time(rs, d);
`ifdef LCD_SEQ_AUTOWRAP_EN
        if (rs) begin
            m_col++;
            if (m_col == 16) begin
                m_col = 0;
                push_exp(ready_at, 1'b0, m_line ? 8'h80 : 8'hC0);
                m_line   = !m_line;
                ready_at = ready_at + WR + EXEC;
            end
        end else if (d != 8'd0 && d < 8'd4) begin
            m_col  = 0;
            m_line = 1'b0;
        end else if (d >= 8'h80) begin
            m_line = d[6];
            m_col  = int'(d[3:0]);
        end
`endif
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ready"}, cmd_if.cmd_ready, 0);
        chk({tag, "_init_done"}, init_done, 0);
        chk({tag, "_start"}, lcd_start, 0);
        chk({tag, "_rs"}, lcd_rs, 0);
        chk({tag, "_rw"}, lcd_rw, 0);
        chk({tag, "_data"}, lcd_data, 0);
        chk({tag, "_busy"}, busy, 1);
    endtask

    task automatic wait_init();
        int n = 0;
        while (init_done !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("init_done_time", cyc, init_exp);
        chk("init_ready", cmd_if.cmd_ready, 1);
        chk("init_busy_low", busy, 0);
        chk("ready_low_during_init", bad_rdy, 0);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (cmd_if.cmd_ready !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("ready_time", cyc, ready_at);
    endtask

    task automatic send(input logic rs, input logic [7:0] d, input int gap);
        int offer;
        int n = 0;
        if (gap > 0) begin
            cmd_if.cmd_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_rs    = rs;
        cmd_if.cmd_data  = d;
        offer = cyc;
        while (cmd_if.cmd_ready !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("accept_time", cyc, (ready_at > offer) ? ready_at : offer);
        model_accept(cyc, rs, d);
        @(negedge clk);
        chk("start_after_accept", lcd_start, 1);
        chk("ready_drops", cmd_if.cmd_ready, 0);
        chk("busy_in_issue", busy, 1);
    endtask

    task automatic compare_log();
        if (exp_q.size() > 0) chk("data_hold", lcd_data, exp_q[exp_q.size() - 1].d);
        chk("event_count", obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            chk("ev_time", obs_q[i].t, exp_q[i].t);
            chk("ev_rs", obs_q[i].rs, exp_q[i].rs);
            chk("ev_data", obs_q[i].d, exp_q[i].d);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_rs    = 1'b0;
        cmd_if.cmd_data  = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");

        // Power-up and init sequence.
        model_init();
        rst = 1'b0;
        wait_init();
        compare_log();

        // Directed: held valid back-to-back, clear vs. data 0x01.
        send(1'b1, 8'h41, 0);
        send(1'b1, 8'h42, 0);
        send(1'b0, 8'h01, 1);
        send(1'b1, 8'h01, 0);
        cmd_if.cmd_valid = 1'b0;
        wait_ready();
        compare_log();

        // Randomized bytes with random gaps.
        for (int i = 0; i < 16; i++) begin
            logic [7:0] d;
            logic       rs;
            case ($urandom_range(0, 3))
                0: begin rs = 1'b1; d = 8'($urandom_range(32, 126)); end
                1: begin rs = 1'b0; d = 8'($urandom_range(1, 3)); end
                2: begin rs = 1'b0; d = 8'($urandom_range(128, 255)); end
                default: begin rs = 1'($urandom); d = 8'($urandom); end
            endcase
            send(rs, d, $urandom_range(0, 2));
        end
        cmd_if.cmd_valid = 1'b0;
        wait_ready();
        compare_log();

        // Reset in the middle of a long wait.
        send(1'b0, 8'h02, 0);
        cmd_if.cmd_valid = 1'b0;
        repeat (5) @(negedge clk);
        compare_log();
        rst = 1'b1;
        #1;
        check_reset_vals("mid_reset");
        repeat (3) @(negedge clk);
        bad_rdy = 1'b0;
        model_init();
        rst = 1'b0;
        wait_init();
        compare_log();

`ifdef LCD_SEQ_AUTOWRAP_EN
        send(1'b0, 8'h01, 0);
        for (int i = 0; i < 32; i++) send(1'b1, 8'(8'h41 + i), 0);
        cmd_if.cmd_valid = 1'b0;
        wait_ready();
        compare_log();
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
